// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: peripheral decode base,
// FSM encoding, master index width and the per-master command bundle.
package dmem_arb_pkg;
  localparam logic [3:0] PERIPH_BASE_DEF = 4'hC;
  localparam int         MIDX_W          = 1;

  typedef logic [MIDX_W-1:0] midx_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;
endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the
// master that did not win last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  midx_t      last,
  output midx_t      sel
);
  always_comb begin
    sel = '0;
    if (req == 2'b11) sel = ~last;
    else if (req[1])  sel = 1'b1;
  end
endmodule

// File: rtl/dmem_arb.sv
// Core/DMA arbiter onto the data RAM and the peripheral (CLIC) port, with a
// one-cycle registered read-return path.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter logic [3:0] PERIPH_BASE = PERIPH_BASE_DEF,
  parameter int         NM          = 2
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [NM-1:0]      m_req,
  input  logic [NM-1:0]      m_we,
  input  logic [32*NM-1:0]   m_addr,
  input  logic [32*NM-1:0]   m_wdata,
  input  logic [4*NM-1:0]    m_wstrb,
  output logic [NM-1:0]      m_gnt,
  output logic [NM-1:0]      m_rvalid,
  output logic [31:0]        m_rdata,
  output logic [31:0]        t_addr,
  output logic               t_we,
  output logic [31:0]        t_wdata,
  output logic [3:0]         t_wstrb,
  output logic               mem_req,
  input  logic               mem_gnt,
  input  logic [31:0]        mem_rdata,
  output logic               per_req,
  input  logic               per_gnt,
  input  logic [31:0]        per_rdata
);
  cmd_t [NM-1:0] cmd;
  state_t        state, state_nxt;
  midx_t         last, lock_idx, rr_sel, sel;
  logic          sel_req, is_per, tgt_gnt, granted;
  logic          rd_pend, rd_per;
  midx_t         rd_idx;

  for (genvar i = 0; i < NM; i++) begin : g_cmd
    assign cmd[i].we    = m_we[i];
    assign cmd[i].addr  = m_addr[32*i +: 32];
    assign cmd[i].wdata = m_wdata[32*i +: 32];
    assign cmd[i].wstrb = m_wstrb[4*i +: 4];
  end

  rr_arb2 u_rr (
    .req  (m_req),
    .last (last),
    .sel  (rr_sel)
  );

  // A stalled master keeps the bus until its target accepts or it withdraws.
  assign sel     = (state == LOCK) ? lock_idx : rr_sel;
  assign sel_req = m_req[sel];
  assign t_addr  = cmd[sel].addr;
  assign t_we    = cmd[sel].we;
  assign t_wdata = cmd[sel].wdata;
  assign t_wstrb = cmd[sel].wstrb;

  assign is_per  = (t_addr[31:28] == PERIPH_BASE);
  assign mem_req = sel_req & ~is_per;
  assign per_req = sel_req &  is_per;
  assign tgt_gnt = is_per ? per_gnt : mem_gnt;
  assign granted = sel_req & tgt_gnt;

  always_comb begin
    m_gnt      = '0;
    m_gnt[sel] = granted;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_req && !tgt_gnt) state_nxt = LOCK;
      LOCK:    if (!sel_req || tgt_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_idx <= '0;
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      rd_per   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= granted & ~t_we;
      if (state == IDLE && state_nxt == LOCK) lock_idx <= sel;
      if (granted) begin
        last   <= sel;
        rd_idx <= sel;
        rd_per <= is_per;
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (rd_pend) m_rvalid[rd_idx] = 1'b1;
  end

  assign m_rdata = !rd_pend ? '0 : (rd_per ? per_rdata : mem_rdata);
endmodule
